// File: rtl/hilo_md_unit.sv
// HI/LO multiply-divide unit: mult/multu/div/divu with fixed 5/10-cycle latency, mthi/mtlo.
// Optional madd/maddu accumulate is enabled by defining MD_MADD_EN.
module hilo_md_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  Op,
  input  logic [31:0] RData1,
  input  logic [31:0] RData2,
  output logic        Busy,
  output logic [31:0] HI_Outcome,
  output logic [31:0] LO_Outcome
);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
`ifdef MD_MADD_EN
  localparam logic [3:0] OpMadd  = 4'd7;
  localparam logic [3:0] OpMaddu = 4'd8;
`endif

  localparam logic [3:0] MulCycles = 4'd5;
  localparam logic [3:0] DivCycles = 4'd10;

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [3:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] hi_q, lo_q;
  logic        busy_q;

  logic        start_mul, start_div;
  logic [63:0] a_sx, b_sx, prod_s, prod_u, mul_res;
  logic        div_signed, a_neg, b_neg, div_zero;
  logic [31:0] mag_a, mag_b, b_safe, q_u, r_u, quo, rem;

  always_comb begin
    start_mul = Start && ((Op == OpMult) || (Op == OpMultu)
`ifdef MD_MADD_EN
                          || (Op == OpMadd) || (Op == OpMaddu)
`endif
                         );
    start_div = Start && ((Op == OpDiv) || (Op == OpDivu));
  end

  always_comb begin
    a_sx   = {{32{a_q[31]}}, a_q};
    b_sx   = {{32{b_q[31]}}, b_q};
    prod_s = a_sx * b_sx;
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    mul_res = prod_u;
    case (op_q)
      OpMult:  mul_res = prod_s;
      OpMultu: mul_res = prod_u;
`ifdef MD_MADD_EN
      OpMadd:  mul_res = {hi_q, lo_q} + prod_s;
      OpMaddu: mul_res = {hi_q, lo_q} + prod_u;
`endif
      default: mul_res = prod_u;
    endcase
  end

  // Signed divide through magnitudes, so 0x80000000 / -1 wraps cleanly to 0x80000000.
  always_comb begin
    div_signed = (op_q == OpDiv);
    a_neg      = div_signed && a_q[31];
    b_neg      = div_signed && b_q[31];
    mag_a      = a_neg ? -a_q : a_q;
    mag_b      = b_neg ? -b_q : b_q;
    div_zero   = (b_q == 32'd0);
    b_safe     = div_zero ? 32'd1 : mag_b;
    q_u        = mag_a / b_safe;
    r_u        = mag_a % b_safe;
    quo        = (a_neg ^ b_neg) ? -q_u : q_u;
    rem        = a_neg ? -r_u : r_u;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_mul || start_div) begin
            state_q <= start_mul ? StMul : StDiv;
            cnt_q   <= start_mul ? MulCycles : DivCycles;
            busy_q  <= 1'b1;
            op_q    <= Op;
            a_q     <= RData1;
            b_q     <= RData2;
          end else if (Start && (Op == OpMthi)) begin
            hi_q <= RData1;
          end else if (Start && (Op == OpMtlo)) begin
            lo_q <= RData1;
          end
        end
        StMul: begin
          if (cnt_q == 4'd1) begin
            state_q      <= StIdle;
            busy_q       <= 1'b0;
            cnt_q        <= 4'd0;
            {hi_q, lo_q} <= mul_res;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StDiv: begin
          if (cnt_q == 4'd1) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            cnt_q   <= 4'd0;
            if (!div_zero) begin
              hi_q <= rem;
              lo_q <= quo;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

  assign Busy       = busy_q;
  assign HI_Outcome = hi_q;
  assign LO_Outcome = lo_q;

endmodule

// File: tb/tb_hilo_md_unit.sv
// Directed self-checking bench for hilo_md_unit; define MD_MADD_EN to also cover madd.
module tb_hilo_md_unit;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [3:0]  Op;
  logic [31:0] RData1, RData2;
  logic        Busy;
  logic [31:0] HI_Outcome, LO_Outcome;

  int tests_run = 0;
  int tests_failed = 0;

  hilo_md_unit dut (
    .clk        (clk),
    .reset      (reset),
    .Start      (Start),
    .Op         (Op),
    .RData1     (RData1),
    .RData2     (RData2),
    .Busy       (Busy),
    .HI_Outcome (HI_Outcome),
    .LO_Outcome (LO_Outcome)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one Start pulse; returns sampled just after the issue edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    Start  = 1'b1;
    Op     = op;
    RData1 = a;
    RData2 = b;
    @(posedge clk);
    #1;
    Start = 1'b0;
    Op    = 4'd0;
  endtask

  // Count Busy-high samples (one per cycle); optionally inject a mult Start at busy cycle 3.
  // Also flags any HI/LO change while Busy is high.
  task automatic wait_busy(input bit inject, output int n, output logic changed);
    logic [31:0] hi0, lo0;
    hi0 = HI_Outcome;
    lo0 = LO_Outcome;
    n = 0;
    changed = 1'b0;
    while (Busy && n < 40) begin
      n++;
      if (HI_Outcome !== hi0 || LO_Outcome !== lo0) changed = 1'b1;
      @(negedge clk);
      if (inject && n == 3) begin
        Start  = 1'b1;
        Op     = 4'd1;
        RData1 = 32'd3;
        RData2 = 32'd4;
      end else begin
        Start  = 1'b0;
        RData1 = 32'hDEAD_BEEF;
        RData2 = 32'h0000_0001;
      end
      @(posedge clk);
      #1;
    end
    Start = 1'b0;
  endtask

  int   n;
  logic chg;
  logic busy_seen;

  initial begin
    reset  = 1'b1;
    Start  = 1'b0;
    Op     = 4'd0;
    RData1 = 32'd0;
    RData2 = 32'd0;
    #2;
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_hi", HI_Outcome, 32'd0);
    check("reset_lo", LO_Outcome, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // mult -1 * 2
    issue(4'd1, 32'hFFFF_FFFF, 32'd2);
    wait_busy(1'b0, n, chg);
    check("mult_busy_cycles", n, 32'd5);
    check("mult_hold", {31'd0, chg}, 32'd0);
    check("mult_hi", HI_Outcome, 32'hFFFF_FFFF);
    check("mult_lo", LO_Outcome, 32'hFFFF_FFFE);

    // multu 0xFFFFFFFF * 2
    issue(4'd2, 32'hFFFF_FFFF, 32'd2);
    wait_busy(1'b0, n, chg);
    check("multu_busy_cycles", n, 32'd5);
    check("multu_hi", HI_Outcome, 32'h0000_0001);
    check("multu_lo", LO_Outcome, 32'hFFFF_FFFE);

    // div -7 / 2 -> q=-3, r=-1
    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    wait_busy(1'b0, n, chg);
    check("div_busy_cycles", n, 32'd10);
    check("div_hold", {31'd0, chg}, 32'd0);
    check("div_lo", LO_Outcome, 32'hFFFF_FFFD);
    check("div_hi", HI_Outcome, 32'hFFFF_FFFF);

    // divu 7 / 0 leaves HI/LO alone
    issue(4'd4, 32'd7, 32'd0);
    wait_busy(1'b0, n, chg);
    check("divu0_busy_cycles", n, 32'd10);
    check("divu0_hi", HI_Outcome, 32'hFFFF_FFFF);
    check("divu0_lo", LO_Outcome, 32'hFFFF_FFFD);

    // signed overflow case
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_busy(1'b0, n, chg);
    check("divovf_lo", LO_Outcome, 32'h8000_0000);
    check("divovf_hi", HI_Outcome, 32'h0000_0000);

    // mthi then mtlo back to back
    busy_seen = 1'b0;
    @(negedge clk);
    Start = 1'b1; Op = 4'd5; RData1 = 32'h1234_5678;
    @(posedge clk); #1;
    busy_seen |= Busy;
    check("mthi_hi", HI_Outcome, 32'h1234_5678);
    @(negedge clk);
    Op = 4'd6; RData1 = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    busy_seen |= Busy;
    Start = 1'b0; Op = 4'd0;
    check("mtlo_lo", LO_Outcome, 32'h9ABC_DEF0);
    check("mthi_keep", HI_Outcome, 32'h1234_5678);
    check("mthilo_busy", {31'd0, busy_seen}, 32'd0);

    // Op none and unsupported codes
    issue(4'd0, 32'h1111_1111, 32'd3);
    check("opnone_busy", {31'd0, Busy}, 32'd0);
    issue(4'd12, 32'h1111_1111, 32'd3);
    check("op12_busy", {31'd0, Busy}, 32'd0);
    check("op12_hi", HI_Outcome, 32'h1234_5678);
    check("op12_lo", LO_Outcome, 32'h9ABC_DEF0);
`ifndef MD_MADD_EN
    issue(4'd7, 32'd3, 32'd4);
    check("madd_off_busy", {31'd0, Busy}, 32'd0);
    issue(4'd8, 32'd3, 32'd4);
    check("maddu_off_busy", {31'd0, Busy}, 32'd0);
    check("madd_off_hi", HI_Outcome, 32'h1234_5678);
    check("madd_off_lo", LO_Outcome, 32'h9ABC_DEF0);
`endif

    // div 100 / 7 with a mult Start injected mid-flight: q=14, r=2
    issue(4'd3, 32'd100, 32'd7);
    wait_busy(1'b1, n, chg);
    check("ignore_busy_cycles", n, 32'd10);
    check("ignore_hold", {31'd0, chg}, 32'd0);
    check("ignore_lo", LO_Outcome, 32'd14);
    check("ignore_hi", HI_Outcome, 32'd2);
    repeat (8) @(posedge clk);
    #1;
    check("ignore_no_restart", {31'd0, Busy}, 32'd0);
    check("ignore_lo_after", LO_Outcome, 32'd14);

    // reset pulse during mult
    issue(4'd1, 32'd3, 32'd5);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_busy", {31'd0, Busy}, 32'd0);
    check("rst_mid_hi", HI_Outcome, 32'd0);
    check("rst_mid_lo", LO_Outcome, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("rst_after_busy", {31'd0, Busy}, 32'd0);
    check("rst_after_lo", LO_Outcome, 32'd0);

    // Start accepted on the first edge after reset release
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; Start = 1'b1; Op = 4'd5; RData1 = 32'h0000_CAFE;
    @(posedge clk); #1;
    Start = 1'b0; Op = 4'd0;
    check("post_rst_mthi", HI_Outcome, 32'h0000_CAFE);

`ifdef MD_MADD_EN
    issue(4'd5, 32'd0, 32'd0);
    issue(4'd6, 32'd5, 32'd0);
    issue(4'd7, 32'd3, 32'd4);
    wait_busy(1'b0, n, chg);
    check("madd_busy_cycles", n, 32'd5);
    check("madd_lo", LO_Outcome, 32'd17);
    check("madd_hi", HI_Outcome, 32'd0);
    // -1 * 1 signed added to 17 -> 16
    issue(4'd7, 32'hFFFF_FFFF, 32'd1);
    wait_busy(1'b0, n, chg);
    check("madd_neg_lo", LO_Outcome, 32'd16);
    check("madd_neg_hi", HI_Outcome, 32'd0);
    // unsigned 0xFFFFFFFF * 1 added to 16 -> {1, 15}
    issue(4'd8, 32'hFFFF_FFFF, 32'd1);
    wait_busy(1'b0, n, chg);
    check("maddu_lo", LO_Outcome, 32'd15);
    check("maddu_hi", HI_Outcome, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
